rr_packet_scheduler_4: RTL and testbench

// - Clocked 4-input round-robin scheduler for spike/weight packets in the SNN accelerator NoC node.
// - Shares one downstream packet channel between four packet sources (PE/neuron-core ports A..D).
// - Tags each forwarded packet with its 2-bit source ID.
// - One registered output stage; valid/ready handshake on every port; fair rotating priority.

---
 rtl/rr_packet_scheduler_4.sv | 115 +++++++++++
 tb/tb_rr_packet_scheduler_4.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_packet_scheduler_4.sv
// 4-input round-robin packet scheduler with one registered output stage and source tagging.
// Optional per-source saturating grant counters are enabled by defining ARB_GRANT_CNT_EN.
module rr_packet_scheduler_4 #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           in_valid,
  input  logic [4*WIDTH-1:0]   in_data,
  output logic [3:0]           in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_src,
  input  logic                 out_ready
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [4*CNT_W-1:0]   grant_cnt
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;
  logic [1:0]       ptr_q, ptr_d;

  logic       load_en;
  logic       has_win;
  logic       accept;
  logic [1:0] winner;
  logic [1:0] idx;

  // Scan from the farthest position back to ptr so the nearest requester wins.
  always_comb begin
    has_win = 1'b0;
    winner  = ptr_q;
    idx     = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (in_valid[idx]) begin
        has_win = 1'b1;
        winner  = idx;
      end
    end
  end

  always_comb begin
    load_en     = !out_valid_q || out_ready;
    accept      = rst_n && has_win && load_en;
    in_ready    = accept ? (4'b0001 << winner) : 4'b0000;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(winner)*WIDTH +: WIDTH];
      out_src_d   = winner;
      ptr_d       = winner + 2'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (in_ready[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_rr_packet_scheduler_4.sv
// Directed self-checking bench for rr_packet_scheduler_4; grant counter test under ARB_GRANT_CNT_EN.
module tb_rr_packet_scheduler_4;

  localparam int unsigned WIDTH = 34;
  localparam int unsigned CNT_W = 4;

  logic               clk;
  logic               rst_n;
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_src;
  logic               out_ready;
`ifdef ARB_GRANT_CNT_EN
  logic [4*CNT_W-1:0] grant_cnt;
`endif

  int n_run;
  int n_fail;

  rr_packet_scheduler_4 #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    in_data = {d, c, b, a};
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'h0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    set_data(34'd1, 34'd2, 34'd3, 34'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if (out_valid !== 1'b0 || out_src !== 2'd0 || in_ready !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got valid=%b src=%0d ready=%b, want 0/0/0000",
                 i, out_valid, out_src, in_ready);
      end
    end
    rst_n = 1'b1;
    #1;
    n_run++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_ready: got %b want 0001", in_ready);
    end
    tick();
    n_run++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 34'd1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got valid=%b src=%0d data=%h, want 1/0/1",
               out_valid, out_src, out_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_data(34'd1, 34'd2, 34'd3, 34'd4);
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_run++;
      if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_data !== 34'(k % 4 + 1)
          || in_ready !== (4'b0001 << ((k + 1) % 4))) begin
        n_fail++;
        $display("FAIL round_robin k=%0d: got valid=%b src=%0d data=%h ready=%b, want 1/%0d/%0d/%b",
                 k, out_valid, out_src, out_data, in_ready, k % 4, k % 4 + 1,
                 4'b0001 << ((k + 1) % 4));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(34'd0, 34'd0, 34'h2_0000_0005, 34'd0);
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    tick();
    set_data(34'd0, 34'd0, 34'h1_2345_6789, 34'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_run++;
      if (out_valid !== 1'b1 || out_data !== 34'h2_0000_0005 || in_ready !== 4'h0) begin
        n_fail++;
        $display("FAIL backpressure cyc%0d: got valid=%b data=%h ready=%b, want 1/200000005/0000",
                 i, out_valid, out_data, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_run++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL backpressure_release_ready: got %b want 0100", in_ready);
    end
    tick();
    n_run++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 34'h1_2345_6789) begin
      n_fail++;
      $display("FAIL backpressure_second: got valid=%b src=%0d data=%h, want 1/2/123456789",
               out_valid, out_src, out_data);
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    set_data(34'd10, 34'd11, 34'd12, 34'd13);
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    tick();
    in_valid = 4'b0010;
    #1;
    n_run++;
    if (in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_ready_b: got %b want 0010", in_ready);
    end
    tick();
    n_run++;
    if (out_src !== 2'd1 || out_data !== 34'd11) begin
      n_fail++;
      $display("FAIL wrap_grant_b: got src=%0d data=%h, want 1/b", out_src, out_data);
    end
    in_valid = 4'b0111;
    #1;
    n_run++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL skip_ready_c: got %b want 0100", in_ready);
    end
    tick();
    n_run++;
    if (out_src !== 2'd2 || out_data !== 34'd12) begin
      n_fail++;
      $display("FAIL skip_grant_c: got src=%0d data=%h, want 2/c", out_src, out_data);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_data(34'h3_AAAA_5555, 34'd2, 34'd3, 34'd4);
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    tick();
    in_valid = 4'h0;
    n_run++;
    if (out_valid !== 1'b1 || out_data !== 34'h3_AAAA_5555) begin
      n_fail++;
      $display("FAIL midop_load: got valid=%b data=%h, want 1/3aaaa5555", out_valid, out_data);
    end
    rst_n = 1'b0;
    tick();
    n_run++;
    if (out_valid !== 1'b0 || out_data !== 34'd0) begin
      n_fail++;
      $display("FAIL midop_discard: got valid=%b data=%h, want 0/0", out_valid, out_data);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    #1;
    n_run++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midop_ptr: got ready=%b want 0001", in_ready);
    end
  endtask

  task automatic test_sole_and_drain();
    do_reset();
    set_data(34'd1, 34'd2, 34'd3, 34'h0_DEAD_BEEF);
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if (out_valid !== 1'b1 || out_src !== 2'd3 || in_ready !== 4'b1000) begin
        n_fail++;
        $display("FAIL sole_d cyc%0d: got valid=%b src=%0d ready=%b, want 1/3/1000",
                 i, out_valid, out_src, in_ready);
      end
    end
    in_valid = 4'h0;
    tick();
    n_run++;
    if (out_valid !== 1'b0 || out_data !== 34'h0_DEAD_BEEF || out_src !== 2'd3) begin
      n_fail++;
      $display("FAIL drain_hold: got valid=%b data=%h src=%0d, want 0/deadbeef/3",
               out_valid, out_data, out_src);
    end
  endtask

`ifdef ARB_GRANT_CNT_EN
  task automatic test_grant_cnt();
    do_reset();
    set_data(34'd1, 34'd2, 34'd3, 34'd4);
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    repeat (20) tick();
    in_valid = 4'h0;
    n_run++;
    if (grant_cnt !== {4'd15, 4'd0, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL grant_cnt_sat: got %h want f000", grant_cnt);
    end
  endtask
`endif

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 4'h0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_midop();
    test_sole_and_drain();
`ifdef ARB_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
